// File: rtl/gradient_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gradient_frame_ctrl
// Purpose  : Frame sequencer ahead of the 3x3 gradient window buffer. Latches
//            frame size, clears the buffer, gates the pixel stream with
//            row blanking, and checks the emitted window count.
// Revision : 1.0 - initial release
// ============================================================================
module gradient_frame_ctrl #(
    parameter int DATAWID   = 12,
    parameter int MAX_DIM   = 1024,
    parameter int MIN_DIM   = 3,
    parameter int CLR_CYC   = 4,
    parameter int LINE_GAP  = 2,
    parameter int DRAIN_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [10:0]        cfg_ih,
    input  logic [10:0]        cfg_iw,
    input  logic               abort,
    input  logic               s_valid,
    input  logic [DATAWID-1:0] s_data,
    output logic               s_ready,
    output logic               buf_rst,
    output logic               buf_din_valid,
    output logic [DATAWID-1:0] buf_din,
    output logic [10:0]        buf_ih,
    output logic [10:0]        buf_iw,
    input  logic               win_valid,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_err,
    output logic               cfg_err,
    output logic [21:0]        win_count
);

    localparam logic [2:0]  c_st_idle   = 3'd0;
    localparam logic [2:0]  c_st_clear  = 3'd1;
    localparam logic [2:0]  c_st_active = 3'd2;
    localparam logic [2:0]  c_st_gap    = 3'd3;
    localparam logic [2:0]  c_st_drain  = 3'd4;
    localparam logic [2:0]  c_st_done   = 3'd5;

    localparam logic [10:0] c_min_dim   = MIN_DIM[10:0];
    localparam logic [10:0] c_max_dim   = MAX_DIM[10:0];
    // Last value of the dwell counter in each timed state.
    localparam logic [7:0]  c_clr_last  = 8'(CLR_CYC - 1);
    localparam logic [7:0]  c_gap_last  = 8'(LINE_GAP - 1);
    localparam logic [7:0]  c_drn_last  = 8'(DRAIN_CYC - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [7:0]  r_cnt;
    logic [10:0] r_row;
    logic [10:0] r_col;

    logic        w_idle;
    logic        w_cfg_ok;
    logic        w_accept;
    logic        w_fire;
    logic        w_last_col;
    logic        w_last_row;
    logic        w_counting;
    logic [21:0] w_win_next;
    logic [21:0] w_exp;

    assign w_idle     = (r_state == c_st_idle);
    assign s_ready    = (r_state == c_st_active);
    assign w_cfg_ok   = (cfg_ih >= c_min_dim) && (cfg_ih <= c_max_dim) &&
                        (cfg_iw >= c_min_dim) && (cfg_iw <= c_max_dim);
    assign w_accept   = w_idle && start && w_cfg_ok;
    assign w_fire     = s_valid && s_ready;
    assign w_last_col = (r_col == buf_iw - 11'd1);
    assign w_last_row = (r_row == buf_ih - 11'd1);
    assign w_counting = (r_state == c_st_clear) || (r_state == c_st_active) ||
                        (r_state == c_st_gap)   || (r_state == c_st_drain);
    // Window count as it will stand after this edge; the DONE check uses it
    // so a window arriving on the final drain cycle is not missed.
    assign w_win_next = (w_counting && win_valid && (win_count != 22'h3F_FFFF)) ?
                        win_count + 22'd1 : win_count;
    assign w_exp      = ({11'd0, buf_ih} - 22'd2) * ({11'd0, buf_iw} - 22'd2);

    // Next-state decode; abort overrides every transition outside IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:   if (w_accept) w_next = c_st_clear;
            c_st_clear:  if (r_cnt == c_clr_last) w_next = c_st_active;
            c_st_active: begin
                if (w_fire && w_last_col) begin
                    if (w_last_row)       w_next = c_st_drain;
                    else if (LINE_GAP > 0) w_next = c_st_gap;
                    else                  w_next = c_st_active;
                end
            end
            c_st_gap:    if (r_cnt == c_gap_last) w_next = c_st_active;
            c_st_drain:  if (r_cnt == c_drn_last) w_next = c_st_done;
            c_st_done:   w_next = c_st_idle;
            default:     w_next = c_st_idle;
        endcase
        if (!w_idle && abort) w_next = c_st_idle;
    end

    // State, dwell counter, registered outputs and pixel position tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_cnt         <= 8'd0;
            r_row         <= 11'd0;
            r_col         <= 11'd0;
            buf_rst       <= 1'b1;
            buf_din_valid <= 1'b0;
            buf_din       <= '0;
            buf_ih        <= 11'd0;
            buf_iw        <= 11'd0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            cfg_err       <= 1'b0;
            win_count     <= 22'd0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
            busy          <= (w_next != c_st_idle);
            buf_rst       <= (w_next == c_st_clear);
            buf_din_valid <= w_fire && !abort;
            if (w_fire && !abort) buf_din <= s_data;
            cfg_err       <= w_idle && start && !w_cfg_ok;
            frame_done    <= (w_next == c_st_done);
            frame_err     <= (w_next == c_st_done) && (w_win_next != w_exp);
            if (w_accept) begin
                buf_ih    <= cfg_ih;
                buf_iw    <= cfg_iw;
                r_row     <= 11'd0;
                r_col     <= 11'd0;
                win_count <= 22'd0;
            end else begin
                win_count <= w_win_next;
                if (w_fire) begin
                    if (w_last_col) begin
                        r_col <= 11'd0;
                        if (!w_last_row) r_row <= r_row + 11'd1;
                    end else begin
                        r_col <= r_col + 11'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gradient_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gradient_frame_ctrl
// Purpose  : Directed self-checking bench for gradient_frame_ctrl with a
//            behavioural 3x3 window buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gradient_frame_ctrl;

    localparam int DATAWID = 12;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [10:0]        cfg_ih = 11'd0;
    logic [10:0]        cfg_iw = 11'd0;
    logic               abort = 1'b0;
    logic               s_valid = 1'b0;
    logic [DATAWID-1:0] s_data = '0;
    logic               win_valid = 1'b0;
    logic               s_ready;
    logic               buf_rst;
    logic               buf_din_valid;
    logic [DATAWID-1:0] buf_din;
    logic [10:0]        buf_ih;
    logic [10:0]        buf_iw;
    logic               busy;
    logic               frame_done;
    logic               frame_err;
    logic               cfg_err;
    logic [21:0]        win_count;

    gradient_frame_ctrl #(
        .DATAWID(DATAWID), .MAX_DIM(1024), .MIN_DIM(3),
        .CLR_CYC(4), .LINE_GAP(2), .DRAIN_CYC(4)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .cfg_ih(cfg_ih), .cfg_iw(cfg_iw),
        .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .buf_rst(buf_rst), .buf_din_valid(buf_din_valid), .buf_din(buf_din),
        .buf_ih(buf_ih), .buf_iw(buf_iw), .win_valid(win_valid), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err), .cfg_err(cfg_err),
        .win_count(win_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Control flags owned by the main sequence.
    bit stat_clr  = 1'b0;
    bit sup_req   = 1'b0;
    int feed_mode = 2;     // 0: valid held high, 1: valid toggles, 2: idle

    // Feeder-owned state.
    int                 acc_cnt = 0;
    logic [DATAWID-1:0] seq = '0;
    logic [DATAWID-1:0] exp_mem [0:63];

    // Monitor-owned statistics.
    int clr_cnt = 0, strobes = 0, bursts = 0, done_cnt = 0, err_cnt = 0;
    int both_cnt = 0, cfgerr_cnt = 0, din_bad = 0, rd_idx = 0, cyc = 0;
    int first_cyc = -1, last_cyc = -1;
    bit prev_v = 1'b0;

    // Model-owned window position.
    int mr = 0, mc = 0;
    bit sup_used = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Upstream source: drives valid/data for the coming edge and records the
    // pixels that will be accepted on it.
    initial forever begin
        @(negedge clk);
        if (stat_clr) acc_cnt = 0;
        case (feed_mode)
            0:       s_valid = 1'b1;
            1:       s_valid = ~s_valid;
            default: s_valid = 1'b0;
        endcase
        seq    = seq + DATAWID'(7);
        s_data = seq;
        if (s_valid && s_ready) begin
            exp_mem[acc_cnt % 64] = s_data;
            acc_cnt++;
        end
    end

    // Window buffer model: a window is complete for every pixel at row>=2
    // and col>=2; optionally drops the first window of a frame.
    initial forever begin
        @(negedge clk);
        win_valid = 1'b0;
        if (buf_rst) begin
            mr = 0; mc = 0; sup_used = 1'b0;
        end else if (buf_din_valid) begin
            if (mr >= 2 && mc >= 2) begin
                if (sup_req && !sup_used) sup_used = 1'b1;
                else                      win_valid = 1'b1;
            end
            if (mc == int'(buf_iw) - 1) begin mc = 0; mr++; end
            else mc++;
        end
    end

    // Output monitor.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (stat_clr) begin
            clr_cnt = 0; strobes = 0; bursts = 0; done_cnt = 0; err_cnt = 0;
            both_cnt = 0; cfgerr_cnt = 0; din_bad = 0; rd_idx = 0;
            first_cyc = -1; last_cyc = -1;
        end
        if (buf_rst && !rst) clr_cnt++;
        if (buf_din_valid) begin
            strobes++;
            if (!prev_v) bursts++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (buf_din !== exp_mem[rd_idx % 64]) din_bad++;
            rd_idx++;
        end
        prev_v = buf_din_valid;
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (frame_done && frame_err) both_cnt++;
        if (cfg_err) cfgerr_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1; step(1); stat_clr = 1'b0;
    endtask

    task automatic pulse_start(input int ih, input int iw);
        cfg_ih = 11'(ih); cfg_iw = 11'(iw); start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin step(1); k++; end
        step(3);
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_cnt < n && k < 400) begin step(1); k++; end
        check_eq("wait_acc", acc_cnt, n);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_buf_rst"}, buf_rst, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_s_ready"}, s_ready, 0);
        check_eq({tag, "_din_valid"}, buf_din_valid, 0);
        check_eq({tag, "_buf_ih"}, buf_ih, 0);
        check_eq({tag, "_buf_iw"}, buf_iw, 0);
        check_eq({tag, "_win_count"}, win_count, 0);
        check_eq({tag, "_frame_done"}, frame_done, 0);
        check_eq({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    initial begin
        rst = 1'b1;
        step(2);
        check_reset_vals("rst");
        rst = 1'b0;
        step(2);

        // Normal 4x5 frame, valid held high.
        feed_mode = 0;
        clear_stats();
        pulse_start(4, 5);
        wait_done(400);
        check_eq("t1_clr_cycles", clr_cnt, 4);
        check_eq("t1_strobes", strobes, 20);
        check_eq("t1_bursts", bursts, 4);
        check_eq("t1_span", last_cyc - first_cyc + 1, 26);
        check_eq("t1_din_order", din_bad, 0);
        check_eq("t1_done", done_cnt, 1);
        check_eq("t1_err", err_cnt, 0);
        check_eq("t1_win_count", win_count, 6);
        check_eq("t1_busy_after", busy, 0);

        // 3x3 frame with bubbly upstream.
        feed_mode = 1;
        clear_stats();
        pulse_start(3, 3);
        wait_done(400);
        check_eq("t3_strobes", strobes, 9);
        check_eq("t3_accepted", acc_cnt, 9);
        check_eq("t3_din_order", din_bad, 0);
        check_eq("t3_win_count", win_count, 1);
        check_eq("t3_done", done_cnt, 1);
        check_eq("t3_err", err_cnt, 0);

        // Illegal configurations are rejected.
        feed_mode = 2;
        clear_stats();
        pulse_start(2, 8);
        step(3);
        check_eq("ill1_cfg_err", cfgerr_cnt, 1);
        check_eq("ill1_busy", busy, 0);
        check_eq("ill1_buf_ih", buf_ih, 3);
        check_eq("ill1_buf_iw", buf_iw, 3);
        check_eq("ill1_no_clear", clr_cnt, 0);
        clear_stats();
        pulse_start(4, 1025);
        step(3);
        check_eq("ill2_cfg_err", cfgerr_cnt, 1);
        check_eq("ill2_busy", busy, 0);
        check_eq("ill2_buf_ih", buf_ih, 3);
        check_eq("ill2_buf_iw", buf_iw, 3);

        // Abort at row 1, col 2 of a 6x6 frame, then a clean 3x3 frame.
        feed_mode = 0;
        clear_stats();
        pulse_start(6, 6);
        wait_acc(9);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_s_ready", s_ready, 0);
        check_eq("abort_din_valid", buf_din_valid, 0);
        step(15);
        check_eq("abort_no_done", done_cnt, 0);
        clear_stats();
        pulse_start(3, 3);
        wait_done(400);
        check_eq("post_abort_clr", clr_cnt, 4);
        check_eq("post_abort_strobes", strobes, 9);
        check_eq("post_abort_win", win_count, 1);
        check_eq("post_abort_done", done_cnt, 1);
        check_eq("post_abort_err", err_cnt, 0);

        // Window count mismatch on a 5x5 frame.
        sup_req = 1'b1;
        clear_stats();
        pulse_start(5, 5);
        wait_done(400);
        sup_req = 1'b0;
        check_eq("mm_done_err_together", both_cnt, 1);
        check_eq("mm_err", err_cnt, 1);
        check_eq("mm_win_count", win_count, 8);

        // start during ACTIVE is ignored.
        clear_stats();
        pulse_start(4, 5);
        wait_acc(7);
        cfg_ih = 11'd9; cfg_iw = 11'd9; start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(400);
        check_eq("busy_start_cfg_err", cfgerr_cnt, 0);
        check_eq("busy_start_ih", buf_ih, 4);
        check_eq("busy_start_iw", buf_iw, 5);
        check_eq("busy_start_strobes", strobes, 20);
        check_eq("busy_start_win", win_count, 6);
        check_eq("busy_start_done", done_cnt, 1);

        // Reset asserted during the row gap.
        clear_stats();
        pulse_start(4, 5);
        wait_acc(5);
        step(1);
        check_eq("gap_s_ready", s_ready, 0);
        check_eq("gap_busy", busy, 1);
        rst = 1'b1;
        step(1);
        check_reset_vals("gap_rst");
        rst = 1'b0;
        feed_mode = 2;
        step(2);
        check_eq("gap_rst_release", buf_rst, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
